// File: rtl/mshr_refill_buf.sv
// MSHR file with line refill buffer: tracks outstanding line misses,
// merges secondary misses, refills critical-word-first, drains in order.
module mshr_refill_buf #(
  parameter int ADR_WIDTH   = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WORD_OFFSET = 2,
  parameter int BYTE_OFFSET = 2,
  parameter int ENTRIES     = 4,
  localparam int ENTRY_BITS = $clog2(ENTRIES)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                alloc_cc2mshr,
  input  logic [ADR_WIDTH-1:0]                adr_cc2mshr,
  output logic                                full_mshr2cc,
  output logic                                hit_mshr2cc,
  output logic [ENTRY_BITS-1:0]               id_mshr2cc,
  output logic                                req_mshr2mem,
  output logic [ADR_WIDTH-1:0]                adr_mshr2mem,
  input  logic                                ack_mem2mshr,
  input  logic [DATA_WIDTH-1:0]               dat_mem2mshr,
  output logic                                crit_vld_mshr2cc,
  output logic [ENTRY_BITS-1:0]               crit_id_mshr2cc,
  output logic [DATA_WIDTH-1:0]               crit_dat_mshr2cc,
  output logic                                fill_vld_mshr2cc,
  output logic [ENTRY_BITS-1:0]               fill_id_mshr2cc,
  output logic [ADR_WIDTH-1:0]                fill_adr_mshr2cc,
  output logic [(DATA_WIDTH<<WORD_OFFSET)-1:0] fill_line_mshr2cc,
  input  logic                                fill_rdy_cc2mshr
);

  localparam int TAG_W = ADR_WIDTH - WORD_OFFSET - BYTE_OFFSET;
  localparam int WORDS = 1 << WORD_OFFSET;

  typedef enum logic [1:0] {FREE, PEND, BUSY, DONE} ent_st_e;

  ent_st_e                st_q   [ENTRIES];
  logic [TAG_W-1:0]       tag_q  [ENTRIES];
  logic [WORD_OFFSET-1:0] crit_q [ENTRIES];
  logic [DATA_WIDTH-1:0]  word_q [ENTRIES][WORDS];

  logic [ENTRY_BITS-1:0]  wr_ptr_q;
  logic [ENTRY_BITS-1:0]  mem_ptr_q;
  logic [ENTRY_BITS-1:0]  rd_ptr_q;
  logic [ENTRY_BITS:0]    count_q;
  logic [ENTRY_BITS:0]    count_d;

  logic                   req_q;
  logic [ADR_WIDTH-1:0]   adr_q;
  logic [WORD_OFFSET-1:0] widx_q;
  logic [WORD_OFFSET-1:0] wcnt_q;
  logic                   crit_vld_q;
  logic [ENTRY_BITS-1:0]  crit_id_q;
  logic [DATA_WIDTH-1:0]  crit_dat_q;

  logic [TAG_W-1:0]       alloc_tag;
  logic [WORD_OFFSET-1:0] alloc_crit;
  logic                   any_match;
  logic [ENTRY_BITS-1:0]  match_id;
  logic                   full;
  logic                   hit;
  logic                   new_alloc;
  logic                   fill_fire;
  logic                   ack_fire;
  logic                   last_word;
  logic                   fetch_start;
  logic                   unused_adr;

  assign alloc_tag  = adr_cc2mshr[ADR_WIDTH-1 -: TAG_W];
  assign alloc_crit = adr_cc2mshr[BYTE_OFFSET +: WORD_OFFSET];
  assign unused_adr = ^adr_cc2mshr[BYTE_OFFSET-1:0];

  assign full        = count_q == (ENTRY_BITS+1)'(ENTRIES);
  assign fill_fire   = fill_vld_mshr2cc & fill_rdy_cc2mshr;
  assign hit         = alloc_cc2mshr & any_match;
  assign new_alloc   = alloc_cc2mshr & ~any_match & ~full;
  assign ack_fire    = req_q & ack_mem2mshr;
  assign last_word   = &wcnt_q;
  assign fetch_start = ~req_q && (st_q[mem_ptr_q] == PEND);

  // An entry draining this cycle is gone; a miss to it must reallocate.
  always_comb begin
    any_match = 1'b0;
    match_id  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!any_match && st_q[i] != FREE &&
          tag_q[i] == alloc_tag &&
          !(fill_fire && rd_ptr_q == ENTRY_BITS'(i))) begin
        any_match = 1'b1;
        match_id  = ENTRY_BITS'(i);
      end
    end
  end

  always_comb begin
    count_d = count_q
            + (ENTRY_BITS+1)'(new_alloc)
            - (ENTRY_BITS+1)'(fill_fire);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) st_q[i] <= FREE;
      wr_ptr_q   <= '0;
      mem_ptr_q  <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      req_q      <= 1'b0;
      adr_q      <= '0;
      widx_q     <= '0;
      wcnt_q     <= '0;
      crit_vld_q <= 1'b0;
      crit_id_q  <= '0;
      crit_dat_q <= '0;
    end else begin
      crit_vld_q <= 1'b0;
      count_q    <= count_d;
      if (new_alloc) begin
        st_q[wr_ptr_q] <= PEND;
        wr_ptr_q       <= wr_ptr_q + ENTRY_BITS'(1);
      end
      if (fill_fire) begin
        st_q[rd_ptr_q] <= FREE;
        rd_ptr_q       <= rd_ptr_q + ENTRY_BITS'(1);
      end
      if (fetch_start) begin
        st_q[mem_ptr_q] <= BUSY;
        req_q  <= 1'b1;
        widx_q <= crit_q[mem_ptr_q];
        wcnt_q <= '0;
        adr_q  <= {tag_q[mem_ptr_q], crit_q[mem_ptr_q],
                   {BYTE_OFFSET{1'b0}}};
      end else if (ack_fire) begin
        widx_q <= widx_q + WORD_OFFSET'(1);
        wcnt_q <= wcnt_q + WORD_OFFSET'(1);
        adr_q[BYTE_OFFSET +: WORD_OFFSET] <= widx_q + WORD_OFFSET'(1);
        if (wcnt_q == '0) begin
          crit_vld_q <= 1'b1;
          crit_id_q  <= mem_ptr_q;
          crit_dat_q <= dat_mem2mshr;
        end
        if (last_word) begin
          st_q[mem_ptr_q] <= DONE;
          req_q           <= 1'b0;
          mem_ptr_q       <= mem_ptr_q + ENTRY_BITS'(1);
        end
      end
    end
  end

  // Payload storage is qualified by entry state, so it needs no reset.
  always_ff @(posedge clk) begin
    if (new_alloc) begin
      tag_q[wr_ptr_q]  <= alloc_tag;
      crit_q[wr_ptr_q] <= alloc_crit;
    end
    if (ack_fire) word_q[mem_ptr_q][widx_q] <= dat_mem2mshr;
  end

  assign full_mshr2cc     = full;
  assign hit_mshr2cc      = hit;
  assign id_mshr2cc       = hit ? match_id : wr_ptr_q;
  assign req_mshr2mem     = req_q;
  assign adr_mshr2mem     = adr_q;
  assign crit_vld_mshr2cc = crit_vld_q;
  assign crit_id_mshr2cc  = crit_id_q;
  assign crit_dat_mshr2cc = crit_dat_q;
  assign fill_vld_mshr2cc = st_q[rd_ptr_q] == DONE;
  assign fill_id_mshr2cc  = fill_vld_mshr2cc ? rd_ptr_q : '0;
  assign fill_adr_mshr2cc = fill_vld_mshr2cc ?
    {tag_q[rd_ptr_q], {(WORD_OFFSET+BYTE_OFFSET){1'b0}}} : '0;

  always_comb begin
    fill_line_mshr2cc = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (fill_vld_mshr2cc)
        fill_line_mshr2cc[w*DATA_WIDTH +: DATA_WIDTH] = word_q[rd_ptr_q][w];
    end
  end

endmodule

// File: tb/tb_mshr_refill_buf.sv
// Directed bench for mshr_refill_buf: scoreboard queues filled at
// allocation time, drained by memory responder and crit/fill monitors.
module tb_mshr_refill_buf;

  logic         clk;
  logic         rst;
  logic         alloc_cc2mshr;
  logic [31:0]  adr_cc2mshr;
  logic         full_mshr2cc;
  logic         hit_mshr2cc;
  logic [1:0]   id_mshr2cc;
  logic         req_mshr2mem;
  logic [31:0]  adr_mshr2mem;
  logic         ack_mem2mshr;
  logic [31:0]  dat_mem2mshr;
  logic         crit_vld_mshr2cc;
  logic [1:0]   crit_id_mshr2cc;
  logic [31:0]  crit_dat_mshr2cc;
  logic         fill_vld_mshr2cc;
  logic [1:0]   fill_id_mshr2cc;
  logic [31:0]  fill_adr_mshr2cc;
  logic [127:0] fill_line_mshr2cc;
  logic         fill_rdy_cc2mshr;

  mshr_refill_buf dut (
    .clk               (clk),
    .rst               (rst),
    .alloc_cc2mshr     (alloc_cc2mshr),
    .adr_cc2mshr       (adr_cc2mshr),
    .full_mshr2cc      (full_mshr2cc),
    .hit_mshr2cc       (hit_mshr2cc),
    .id_mshr2cc        (id_mshr2cc),
    .req_mshr2mem      (req_mshr2mem),
    .adr_mshr2mem      (adr_mshr2mem),
    .ack_mem2mshr      (ack_mem2mshr),
    .dat_mem2mshr      (dat_mem2mshr),
    .crit_vld_mshr2cc  (crit_vld_mshr2cc),
    .crit_id_mshr2cc   (crit_id_mshr2cc),
    .crit_dat_mshr2cc  (crit_dat_mshr2cc),
    .fill_vld_mshr2cc  (fill_vld_mshr2cc),
    .fill_id_mshr2cc   (fill_id_mshr2cc),
    .fill_adr_mshr2cc  (fill_adr_mshr2cc),
    .fill_line_mshr2cc (fill_line_mshr2cc),
    .fill_rdy_cc2mshr  (fill_rdy_cc2mshr)
  );

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] dat;
  } crit_t;

  typedef struct packed {
    logic [1:0]   id;
    logic [31:0]  adr;
    logic [127:0] line;
  } fill_t;

  logic [31:0] exp_adr_q [$];
  crit_t       exp_crit_q[$];
  fill_t       exp_fill_q[$];

  int checks = 0;
  int errors = 0;
  int acks   = 0;
  int fills  = 0;
  int ack_budget = 1000;
  bit mem_en = 1'b1;
  bit gap    = 1'b0;
  bit gap_ph = 1'b0;
  bit stray  = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line 0x123 holds 0xA0..0xA3; other lines are offset by 0x100 per line.
  function automatic logic [31:0] mdat(input logic [31:0] a);
    logic [31:0] l;
    l = {4'h0, a[31:4]} - 32'h123;
    return (l << 8) + 32'hA0 + {30'd0, a[3:2]};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_line(input logic [31:0] a, input logic [1:0] id);
    logic [31:0] base;
    logic [1:0]  w;
    crit_t c;
    fill_t f;
    base = {a[31:4], 4'h0};
    f.id = id;
    f.adr = base;
    f.line = '0;
    for (int k = 0; k < 4; k++) begin
      w = a[3:2] + 2'(k);
      exp_adr_q.push_back(base | {28'd0, w, 2'b00});
      f.line[k*32 +: 32] = mdat(base | {28'd0, 2'(k), 2'b00});
    end
    c.id = id;
    c.dat = mdat({a[31:2], 2'b00});
    exp_crit_q.push_back(c);
    exp_fill_q.push_back(f);
  endtask

  task automatic alloc(input logic [31:0] a, input logic e_hit,
                       input logic [1:0] e_id, input bit chk_id,
                       input bit push);
    alloc_cc2mshr = 1'b1;
    adr_cc2mshr = a;
    #1;
    chk("alloc_hit", hit_mshr2cc, e_hit);
    if (chk_id) chk("alloc_id", id_mshr2cc, e_id);
    if (push) push_line(a, e_id);
    @(posedge clk);
    #1;
    alloc_cc2mshr = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"},      req_mshr2mem, 0);
    chk({tag, "_adr"},      adr_mshr2mem, 0);
    chk({tag, "_critvld"},  crit_vld_mshr2cc, 0);
    chk({tag, "_critid"},   crit_id_mshr2cc, 0);
    chk({tag, "_critdat"},  crit_dat_mshr2cc, 0);
    chk({tag, "_fillvld"},  fill_vld_mshr2cc, 0);
    chk({tag, "_fillid"},   fill_id_mshr2cc, 0);
    chk({tag, "_filladr"},  fill_adr_mshr2cc, 0);
    chk({tag, "_fillline"}, fill_line_mshr2cc, 0);
    chk({tag, "_full"},     full_mshr2cc, 0);
    chk({tag, "_hit"},      hit_mshr2cc, 0);
    chk({tag, "_id"},       id_mshr2cc, 0);
  endtask

  task automatic clear_sb();
    exp_adr_q.delete();
    exp_crit_q.delete();
    exp_fill_q.delete();
    acks = 0;
    fills = 0;
  endtask

  task automatic do_reset();
    alloc_cc2mshr = 1'b0;
    fill_rdy_cc2mshr = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    clear_sb();
    gap = 1'b0;
    gap_ph = 1'b0;
    mem_en = 1'b1;
    ack_budget = 1000;
  endtask

  task automatic wait_drain(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      if (exp_adr_q.size() == 0 && exp_crit_q.size() == 0 &&
          exp_fill_q.size() == 0) break;
      tick();
    end
    chk({tag, "_adr_left"},  exp_adr_q.size(), 0);
    chk({tag, "_crit_left"}, exp_crit_q.size(), 0);
    chk({tag, "_fill_left"}, exp_fill_q.size(), 0);
  endtask

  task automatic wait_fill_vld(input string tag, input int max);
    for (int i = 0; i < max && !fill_vld_mshr2cc; i++) tick();
    chk({tag, "_fill_vld"}, fill_vld_mshr2cc, 1'b1);
  endtask

  // Memory responder; checks the requested address against the scoreboard.
  initial begin
    ack_mem2mshr = 1'b0;
    dat_mem2mshr = '0;
    forever begin
      @(negedge clk);
      ack_mem2mshr = 1'b0;
      if (stray) begin
        ack_mem2mshr = 1'b1;
        dat_mem2mshr = 32'hDEAD_BEEF;
      end else if (!rst && mem_en && req_mshr2mem && ack_budget > 0) begin
        chk("mem_adr_pending", exp_adr_q.size() != 0, 1'b1);
        if (gap && !gap_ph) begin
          gap_ph = 1'b1;
          if (exp_adr_q.size() != 0)
            chk("mem_adr_stable", adr_mshr2mem, exp_adr_q[0]);
        end else begin
          gap_ph = 1'b0;
          if (exp_adr_q.size() != 0)
            chk("mem_adr", adr_mshr2mem, exp_adr_q.pop_front());
          ack_mem2mshr = 1'b1;
          dat_mem2mshr = mdat(adr_mshr2mem);
          ack_budget--;
          acks++;
        end
      end
    end
  end

  initial begin
    crit_t c;
    forever begin
      @(negedge clk);
      if (crit_vld_mshr2cc) begin
        chk("crit_expected", exp_crit_q.size() != 0, 1'b1);
        if (exp_crit_q.size() != 0) begin
          c = exp_crit_q.pop_front();
          chk("crit_id", crit_id_mshr2cc, c.id);
          chk("crit_dat", crit_dat_mshr2cc, c.dat);
        end
      end
    end
  end

  initial begin
    fill_t f;
    forever begin
      @(negedge clk);
      if (fill_vld_mshr2cc && fill_rdy_cc2mshr) begin
        fills++;
        chk("fill_expected", exp_fill_q.size() != 0, 1'b1);
        if (exp_fill_q.size() != 0) begin
          f = exp_fill_q.pop_front();
          chk("fill_id", fill_id_mshr2cc, f.id);
          chk("fill_adr", fill_adr_mshr2cc, f.adr);
          chk("fill_line", fill_line_mshr2cc, f.line);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    alloc_cc2mshr = 1'b0;
    adr_cc2mshr = '0;
    fill_rdy_cc2mshr = 1'b1;
    #1;
    chk_zero("init");
    do_reset();
    chk_zero("post_reset");

    // single miss, critical word first
    alloc(32'h0000_1238, 1'b0, 2'd0, 1'b1, 1'b1);
    chk("single_full", full_mshr2cc, 1'b0);
    wait_drain("single", 60);
    chk("single_acks", acks, 4);

    // secondary miss merges into pending entry
    do_reset();
    alloc(32'h0000_1238, 1'b0, 2'd0, 1'b1, 1'b1);
    alloc(32'h0000_1234, 1'b1, 2'd0, 1'b1, 1'b0);
    wait_drain("merge", 60);
    tick(3);
    chk("merge_acks", acks, 4);
    chk("merge_fills", fills, 1);

    // fill all entries, overflow alloc ignored, reuse after one drain
    do_reset();
    mem_en = 1'b0;
    fill_rdy_cc2mshr = 1'b0;
    alloc(32'h0000_1000, 1'b0, 2'd0, 1'b1, 1'b1);
    alloc(32'h0000_2004, 1'b0, 2'd1, 1'b1, 1'b1);
    alloc(32'h0000_3008, 1'b0, 2'd2, 1'b1, 1'b1);
    chk("full_at3", full_mshr2cc, 1'b0);
    alloc(32'h0000_400C, 1'b0, 2'd3, 1'b1, 1'b1);
    chk("full_at4", full_mshr2cc, 1'b1);
    alloc(32'h0000_5000, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("full_after5", full_mshr2cc, 1'b1);
    mem_en = 1'b1;
    wait_fill_vld("full", 60);
    chk("full_before_drain", full_mshr2cc, 1'b1);
    fill_rdy_cc2mshr = 1'b1;
    tick();
    fill_rdy_cc2mshr = 1'b0;
    chk("full_after_drain", full_mshr2cc, 1'b0);
    alloc(32'h0000_5000, 1'b0, 2'd0, 1'b1, 1'b1);
    fill_rdy_cc2mshr = 1'b1;
    wait_drain("full", 300);
    chk("full_fills", fills, 5);

    // acks one cycle in two
    do_reset();
    gap = 1'b1;
    alloc(32'h0000_2224, 1'b0, 2'd0, 1'b1, 1'b1);
    wait_drain("gap", 80);
    gap = 1'b0;

    // drain back-pressure while second line is fetched
    do_reset();
    fill_rdy_cc2mshr = 1'b0;
    alloc(32'h0000_3008, 1'b0, 2'd0, 1'b1, 1'b1);
    alloc(32'h0000_4004, 1'b0, 2'd1, 1'b1, 1'b1);
    wait_fill_vld("bp", 40);
    for (int i = 0; i < 10; i++) begin
      chk("bp_vld_hold", fill_vld_mshr2cc, 1'b1);
      chk("bp_id_hold", fill_id_mshr2cc, exp_fill_q[0].id);
      chk("bp_adr_hold", fill_adr_mshr2cc, exp_fill_q[0].adr);
      chk("bp_line_hold", fill_line_mshr2cc, exp_fill_q[0].line);
      tick();
    end
    chk("bp_second_fetched", exp_adr_q.size(), 0);
    fill_rdy_cc2mshr = 1'b1;
    wait_drain("bp", 40);
    chk("bp_fills", fills, 2);

    // reset in the middle of a line refill
    do_reset();
    ack_budget = 2;
    alloc(32'h0000_5558, 1'b0, 2'd0, 1'b1, 1'b1);
    for (int i = 0; i < 40 && acks < 2; i++) tick();
    chk("mid_acks", acks, 2);
    tick();
    rst = 1'b1;
    #1;
    chk_zero("mid_rst");
    clear_sb();
    tick();
    rst = 1'b0;
    stray = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stray_req", req_mshr2mem, 1'b0);
      chk("stray_crit", crit_vld_mshr2cc, 1'b0);
      chk("stray_fill", fill_vld_mshr2cc, 1'b0);
    end
    stray = 1'b0;
    ack_budget = 1000;
    tick();
    alloc(32'h0000_5558, 1'b0, 2'd0, 1'b1, 1'b1);
    wait_drain("mid", 60);
    chk("mid_refill_acks", acks, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
